regfile_read_arbiter: RTL and testbench
=======================================

// Module: regfile_read_arbiter
// PURPOSE
//  Round-robin arbiter sharing one 32x64 register-file read port among NUM_REQ requesters
//  (decode operand fetch, store-data fetch, debug peek, ...).
//  Accepts one read request per cycle and drives the regfile read-select.
//  Captures the regfile mux output and returns it to the winning requester.
//  Fully pipelined: 2-cycle accept-to-response latency, 1 read/cycle throughput.
// PARAMETERS
//  NUM_REQ  4   number of requesters (2..8)
//  DATA_W   64  regfile read-data width
//  ADDR_W   5   register index width (32 registers)
// PORTS
//  clk           in   1               clock, all state on rising edge
//  reset         in   1               synchronous, active-high reset
//  hold          in   1               1 = issue no new grants; in-flight reads still complete
//  req_valid     in   NUM_REQ         per-requester read request
//  req_addr      in   NUM_REQ*ADDR_W  register index; requester i at [i*ADDR_W +: ADDR_W]
//  req_lock      in   NUM_REQ         request to keep the port (used only with REGFILE_ARB_LOCK_EN)
//  req_ready     out  NUM_REQ         one-hot grant, combinational; accept = valid & ready
//  rf_ReadRegister out ADDR_W         registered read-select to the regfile read mux
//  rf_ReadData   in   DATA_W          combinational regfile read data for rf_ReadRegister
//  rsp_valid     out  NUM_REQ         one-hot, 1-cycle pulse: rsp_data belongs to that requester
//  rsp_data      out  DATA_W          registered read data
// BEHAVIOUR
//  - Reset (sync): rr_ptr=0, s1_valid=0, rsp_valid=0, rsp_data=0, rf_ReadRegister=5'd31, lock FSM=UNLOCKED.
//    req_ready=0 in any cycle where reset=1.
//  - Arbitration (cycle N): search req_valid from index rr_ptr upward, wrapping mod NUM_REQ.
//    The first set bit wins; req_ready[win]=1, all other bits 0.
//    No winner if hold=1 or req_valid=0.
//  - On accept: rr_ptr <= (win+1) mod NUM_REQ, rf_ReadRegister <= req_addr[win],
//    s1_valid<=1, s1_id<=win. Otherwise s1_valid<=0 and rf_ReadRegister holds.
//  - Cycle N+1: regfile mux resolves. If s1_valid: rsp_data <= rf_ReadData, rsp_valid <= onehot(s1_id).
//    Else rsp_valid <= 0 and rsp_data holds.
//  - Cycle N+2: rsp_valid[win]=1 for exactly one cycle. There is no response backpressure;
//    requesters must take the data.
//  - Back-to-back accepts are legal every cycle; responses return in accept order.
//  - hold asserted mid-stream: grants stop that cycle. Accepted reads still produce responses.
//  - Reset mid-operation: all in-flight reads are dropped; rsp_valid=0 on the cycle after reset.
//  - Register 31 is forwarded as the regfile returns it; no special casing here.
//  - Single requester, always valid: granted every cycle.
//  - Requester deasserting valid after accept does not cancel its response.
// CONFIGURATION
//  REGFILE_ARB_LOCK_EN defined:
//    Lock FSM states UNLOCKED / LOCKED(owner).
//    UNLOCKED -> LOCKED(win) on accept with req_lock[win]=1.
//    In LOCKED, only the owner may be granted; others see ready=0; rr_ptr is frozen.
//    LOCKED -> UNLOCKED on an owner accept with req_lock[owner]=0, or a cycle with
//    req_valid[owner]=0. On unlock, rr_ptr <= (owner+1) mod NUM_REQ.
//    hold does not change the lock state.
//  REGFILE_ARB_LOCK_EN undefined: req_lock is ignored; FSM is absent; pure round-robin.
// TESTING
//  1) Reset, req_valid=4'b0001, addr0=5 with rf X5=64'hDEAD -> ready[0] in cycle N;
//     rsp_valid=4'b0001 and rsp_data=64'hDEAD in cycle N+2.
//  2) req_valid=4'b1111 held 8 cycles, rr_ptr=0 -> grant order 0,1,2,3,0,1,2,3;
//     responses in the same order, 2 cycles late.
//  3) req_valid=4'b1010 from rr_ptr=2 -> grant 3, then 1, then 3. Requester 0 and 2 ready stay 0.
//  4) hold=1 for 3 cycles during a 4'b1111 stream -> no ready during hold;
//     the 2 in-flight responses still arrive; resumes at the saved rr_ptr.
//  5) reset pulse one cycle after an accept -> no rsp_valid follows;
//     rf_ReadRegister=31, rsp_data=0.
//  6) [LOCK_EN] req 1 with lock=1 for 3 grants, others valid -> grants 1,1,1;
//     with lock=0 on the 4th, grants resume at 2,3,0.

Source files
------------

// File: rtl/regfile_read_arbiter.sv
// Round-robin arbiter sharing one register-file read port among NUM_REQ requesters.
// Accept in cycle N, read-select registered at the end of N, data captured at the
// end of N+1, response visible in N+2. One new read can be accepted every cycle.
// Optional lock support is compiled in with `define REGFILE_ARB_LOCK_EN.
module regfile_read_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned ADDR_W  = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      hold,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ-1:0]        req_lock,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [ADDR_W-1:0]         rf_ReadRegister,
  input  logic [DATA_W-1:0]         rf_ReadData,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data
);

  localparam int unsigned PtrW = $clog2(NUM_REQ);
  typedef logic [PtrW-1:0] ptr_t;
  localparam ptr_t LastIdx = ptr_t'(NUM_REQ - 1);

  function automatic ptr_t ptr_inc(ptr_t p);
    return (p == LastIdx) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(ptr_t p);
    logic [NUM_REQ-1:0] v;
    v    = '0;
    v[p] = 1'b1;
    return v;
  endfunction

  ptr_t               rr_ptr_q, rr_ptr_d;
  ptr_t               win, idx;
  logic [PtrW:0]      sum;
  logic               found, accept;
  logic [NUM_REQ-1:0] cand;
  logic               locked, unlock;
  logic               s1_valid;
  ptr_t               s1_id;

`ifdef REGFILE_ARB_LOCK_EN
  typedef enum logic [0:0] {StUnlocked, StLocked} lock_state_e;
  lock_state_e state_q, state_d;
  ptr_t        owner_q, owner_d;

  // Lock state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StUnlocked;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  // Lock next state; hold freezes the lock entirely
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    unlock  = 1'b0;
    case (state_q)
      StUnlocked: begin
        if (accept && req_lock[win]) begin
          state_d = StLocked;
          owner_d = win;
        end
      end
      StLocked: begin
        if (!hold && (!req_valid[owner_q] || (accept && !req_lock[owner_q]))) begin
          state_d = StUnlocked;
          unlock  = 1'b1;
        end
      end
      default: state_d = StUnlocked;
    endcase
  end

  // Lock outputs: while locked only the owner is a candidate
  always_comb begin
    locked = (state_q == StLocked);
    cand   = locked ? (req_valid & onehot(owner_q)) : req_valid;
  end
`else
  logic unused_lock;
  assign unused_lock = ^req_lock;

  // Pure round-robin: every valid requester is a candidate
  always_comb begin
    locked = 1'b0;
    unlock = 1'b0;
    cand   = req_valid;
  end
`endif

  // Round-robin search starting at rr_ptr, wrapping mod NUM_REQ
  always_comb begin
    found = 1'b0;
    win   = '0;
    sum   = '0;
    idx   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, rr_ptr_q} + (PtrW+1)'(i);
      if (sum >= (PtrW+1)'(NUM_REQ)) sum = sum - (PtrW+1)'(NUM_REQ);
      idx = sum[PtrW-1:0];
      if (!found && cand[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    accept    = !reset && !hold && found;
    req_ready = accept ? onehot(win) : '0;
  end

  // Pointer advance; frozen while a lock is held
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (unlock) begin
`ifdef REGFILE_ARB_LOCK_EN
      rr_ptr_d = ptr_inc(owner_q);
`endif
    end else if (accept && !locked) begin
      rr_ptr_d = ptr_inc(win);
    end
  end

  // Two-stage read pipeline: select register, then capture regfile data
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q        <= '0;
      s1_valid        <= 1'b0;
      s1_id           <= '0;
      rf_ReadRegister <= '1;
      rsp_valid       <= '0;
      rsp_data        <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      s1_valid <= accept;
      if (accept) begin
        s1_id           <= win;
        rf_ReadRegister <= req_addr[32'(win)*ADDR_W +: ADDR_W];
      end
      rsp_valid <= s1_valid ? onehot(s1_id) : '0;
      if (s1_valid) rsp_data <= rf_ReadData;
    end
  end

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Directed self-checking bench for regfile_read_arbiter (NUM_REQ=4, DATA_W=64, ADDR_W=5).
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_regfile_read_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        hold;
  logic [3:0]  req_valid;
  logic [19:0] req_addr;
  logic [3:0]  req_lock;
  logic [3:0]  req_ready;
  logic [4:0]  rf_ReadRegister;
  logic [63:0] rf_ReadData;
  logic [3:0]  rsp_valid;
  logic [63:0] rsp_data;

  int checks   = 0;
  int failures = 0;

  regfile_read_arbiter #(
    .NUM_REQ(4),
    .DATA_W (64),
    .ADDR_W (5)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .hold           (hold),
    .req_valid      (req_valid),
    .req_addr       (req_addr),
    .req_lock       (req_lock),
    .req_ready      (req_ready),
    .rf_ReadRegister(rf_ReadRegister),
    .rf_ReadData    (rf_ReadData),
    .rsp_valid      (rsp_valid),
    .rsp_data       (rsp_data)
  );

  always #5 clk = ~clk;

  // Regfile contents: register 5 holds DEAD, others a tagged index
  function automatic logic [63:0] rf_val(logic [4:0] a);
    return (a == 5'd5) ? 64'hDEAD : (64'hC0DE_0000_0000_0000 | 64'(a));
  endfunction

  assign rf_ReadData = rf_val(rf_ReadRegister);

  // Requester i reads register addr_tab[i]
  function automatic logic [4:0] addr_tab(int id);
    case (id)
      0:       return 5'd5;
      1:       return 5'd10;
      2:       return 5'd11;
      default: return 5'd12;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset     = 1'b1;
    hold      = 1'b0;
    req_valid = 4'b1111;
    req_lock  = 4'b0000;
    req_addr  = {5'd12, 5'd11, 5'd10, 5'd5};

    // Reset state; ready forced low while reset is high
    tick();
    tick();
    @(negedge clk);
    chk("reset_ready", 64'(req_ready), 64'h0);
    chk("reset_rfsel", 64'(rf_ReadRegister), 64'd31);
    chk("reset_rspv", 64'(rsp_valid), 64'h0);
    chk("reset_rspd", rsp_data, 64'h0);
    tick();

    // 1) single read of register 5
    reset     = 1'b0;
    req_valid = 4'b0001;
    @(negedge clk);
    chk("t1_ready", 64'(req_ready), 64'h1);
    tick();
    req_valid = 4'b0000;
    @(negedge clk);
    chk("t1_rfsel", 64'(rf_ReadRegister), 64'd5);
    chk("t1_rspv_n1", 64'(rsp_valid), 64'h0);
    tick();
    @(negedge clk);
    chk("t1_rspv", 64'(rsp_valid), 64'h1);
    chk("t1_rspd", rsp_data, 64'hDEAD);
    tick();
    @(negedge clk);
    chk("t1_rspv_pulse", 64'(rsp_valid), 64'h0);
    tick();

    // 2) all requesting for 8 cycles from rr_ptr=0
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      req_valid = (k < 8) ? 4'b1111 : 4'b0000;
      @(negedge clk);
      chk($sformatf("t2_ready_%0d", k), 64'(req_ready),
          (k < 8) ? 64'(4'b0001 << (k % 4)) : 64'h0);
      if (k >= 2) begin
        chk($sformatf("t2_rspv_%0d", k), 64'(rsp_valid), 64'(4'b0001 << ((k - 2) % 4)));
        chk($sformatf("t2_rspd_%0d", k), rsp_data, rf_val(addr_tab((k - 2) % 4)));
      end
      tick();
    end

    // 3) move rr_ptr to 2 via a grant to 1, then 4'b1010 -> 3, 1, 3
    req_valid = 4'b0010;
    @(negedge clk);
    chk("t3_pre", 64'(req_ready), 64'h2);
    tick();
    req_valid = 4'b1010;
    @(negedge clk);
    chk("t3_g0", 64'(req_ready), 64'h8);
    tick();
    @(negedge clk);
    chk("t3_g1", 64'(req_ready), 64'h2);
    tick();
    @(negedge clk);
    chk("t3_g2", 64'(req_ready), 64'h8);
    tick();
    req_valid = 4'b0000;
    tick();
    tick();

    // 4) hold for 3 cycles in a full stream starting at rr_ptr=0
    req_valid = 4'b1111;
    @(negedge clk);
    chk("t4_g0", 64'(req_ready), 64'h1);
    tick();
    @(negedge clk);
    chk("t4_g1", 64'(req_ready), 64'h2);
    tick();
    hold = 1'b1;
    @(negedge clk);
    chk("t4_hold0_ready", 64'(req_ready), 64'h0);
    chk("t4_hold0_rspv", 64'(rsp_valid), 64'h1);
    chk("t4_hold0_rspd", rsp_data, 64'hDEAD);
    tick();
    @(negedge clk);
    chk("t4_hold1_ready", 64'(req_ready), 64'h0);
    chk("t4_hold1_rspv", 64'(rsp_valid), 64'h2);
    chk("t4_hold1_rspd", rsp_data, rf_val(5'd10));
    tick();
    @(negedge clk);
    chk("t4_hold2_ready", 64'(req_ready), 64'h0);
    chk("t4_hold2_rspv", 64'(rsp_valid), 64'h0);
    tick();
    hold = 1'b0;
    @(negedge clk);
    chk("t4_resume", 64'(req_ready), 64'h4);
    tick();
    req_valid = 4'b0000;
    tick();
    @(negedge clk);
    chk("t4_last_rspv", 64'(rsp_valid), 64'h4);
    chk("t4_last_rspd", rsp_data, rf_val(5'd11));
    tick();

    // 5) reset one cycle after an accept drops the read
    req_valid = 4'b0001;
    @(negedge clk);
    chk("t5_accept", 64'(req_ready), 64'h1);
    tick();
    reset     = 1'b1;
    req_valid = 4'b1111;
    @(negedge clk);
    chk("t5_reset_ready", 64'(req_ready), 64'h0);
    tick();
    reset     = 1'b0;
    req_valid = 4'b0000;
    @(negedge clk);
    chk("t5_rspv", 64'(rsp_valid), 64'h0);
    chk("t5_rfsel", 64'(rf_ReadRegister), 64'd31);
    chk("t5_rspd", rsp_data, 64'h0);
    tick();
    @(negedge clk);
    chk("t5_rspv_late", 64'(rsp_valid), 64'h0);
    tick();

`ifdef REGFILE_ARB_LOCK_EN
    // 6) requester 1 locks for 3 grants, releases on the 4th, then 2, 3, 0
    req_valid = 4'b0010;
    req_lock  = 4'b0010;
    @(negedge clk);
    chk("t6_lock0", 64'(req_ready), 64'h2);
    tick();
    req_valid = 4'b1111;
    @(negedge clk);
    chk("t6_lock1", 64'(req_ready), 64'h2);
    tick();
    @(negedge clk);
    chk("t6_lock2", 64'(req_ready), 64'h2);
    tick();
    req_lock = 4'b0000;
    @(negedge clk);
    chk("t6_release", 64'(req_ready), 64'h2);
    tick();
    @(negedge clk);
    chk("t6_after0", 64'(req_ready), 64'h4);
    tick();
    @(negedge clk);
    chk("t6_after1", 64'(req_ready), 64'h8);
    tick();
    @(negedge clk);
    chk("t6_after2", 64'(req_ready), 64'h1);
    tick();
    req_valid = 4'b0000;
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
